// File: rtl/spram_req_ctrl.sv
// Round-robin write/read arbiter for the 256x128 byte-maskable single-port SRAM.
// Read data lands in a credit-protected response FIFO so the consumer may stall.
module spram_req_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 128,
    parameter int BE_W      = 16,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ram_ceb,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic [BE_W-1:0]   ram_bweb,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(RSP_DEPTH - 1);

    logic              last_rd;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];

    logic              push;
    logic              pop;
    logic [CNT_W:0]    occ;
    logic              credit;
    logic              wr_elig;
    logic              rd_elig;
    logic              grant_wr;
    logic              grant_rd;

    assign push      = inflight;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];
    assign busy      = inflight | rsp_valid;

    // Occupancy a new read would see: buffered + in flight, minus this cycle's pop.
    assign occ    = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign credit = (occ < DEPTH_C);

    assign wr_elig = rst_n & wr_valid;
    assign rd_elig = rst_n & rd_valid & credit;

    // Grant one requester per cycle; alternate when both are eligible.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_elig && rd_elig) begin
            grant_wr = last_rd;
            grant_rd = ~last_rd;
        end else begin
            grant_wr = wr_elig;
            grant_rd = rd_elig;
        end
    end

    assign wr_ready = grant_wr;
    assign rd_ready = grant_rd;

    // RAM pins follow the grant in the handshake cycle; idle when nothing granted.
    always_comb begin
        ram_ceb  = 1'b1;
        ram_web  = 1'b1;
        ram_a    = '0;
        ram_d    = '0;
        ram_bweb = '1;
        if (grant_wr) begin
            ram_ceb  = 1'b0;
            ram_web  = 1'b0;
            ram_a    = wr_addr;
            ram_d    = wr_data;
            ram_bweb = ~wr_be;
        end else if (grant_rd) begin
            ram_ceb  = 1'b0;
            ram_a    = rd_addr;
        end
    end

    // Arbiter history and read-in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd  <= 1'b1;
            inflight <= 1'b0;
        end else begin
            if (grant_wr) begin
                last_rd <= 1'b0;
            end else if (grant_rd) begin
                last_rd <= 1'b1;
            end
            inflight <= grant_rd;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Response FIFO storage; captures RAM data the cycle after a read grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= ram_q;
        end
    end

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Self-checking bench for spram_req_ctrl with a behavioural SRAM and a
// memory/queue reference model driven from the request handshakes.
module tb_spram_req_ctrl;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [7:0]   wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_be;
    logic         rd_valid;
    logic         rd_ready;
    logic [7:0]   rd_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         ram_ceb;
    logic         ram_web;
    logic [7:0]   ram_a;
    logic [127:0] ram_d;
    logic [15:0]  ram_bweb;
    logic [127:0] ram_q;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] ref_mem [256];
    logic [127:0] ram [256];
    bit           ram_init = 1'b0;

    spram_req_ctrl #(
        .ADDR_W(8), .DATA_W(128), .BE_W(16), .RSP_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_a(ram_a), .ram_d(ram_d),
        .ram_bweb(ram_bweb), .ram_q(ram_q), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM, 1-cycle read latency, active-low controls.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            ram_init <= 1'b1;
        end else if (!ram_ceb) begin
            if (!ram_web) begin
                for (int b = 0; b < 16; b++)
                    if (!ram_bweb[b]) ram[ram_a][8*b +: 8] <= ram_d[8*b +: 8];
            end else begin
                ram_q <= ram[ram_a];
            end
        end
    end

    // Reference model: memory image updated on write handshakes, expected
    // responses queued on read handshakes, compared in order on each pop.
    task automatic scoreboard();
        logic [127:0] q[$];
        logic [127:0] exp_d;
        logic [127:0] prev_data;
        bit           prev_stall;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                n_checks++;
                if ((wr_ready && !wr_valid) || (rd_ready && !rd_valid) ||
                    (wr_ready && rd_ready)) begin
                    n_fail++;
                    $display("FAIL ready_protocol: wr_v=%b wr_r=%b rd_v=%b rd_r=%b",
                             wr_valid, wr_ready, rd_valid, rd_ready);
                end
                n_checks++;
                if (wr_valid && wr_ready) begin
                    if (ram_ceb !== 1'b0 || ram_web !== 1'b0 || ram_a !== wr_addr ||
                        ram_d !== wr_data || ram_bweb !== ~wr_be) begin
                        n_fail++;
                        $display("FAIL ram_write_drive: ceb=%b web=%b a=%h bweb=%h, required 0 0 %h %h",
                                 ram_ceb, ram_web, ram_a, ram_bweb, wr_addr, ~wr_be);
                    end
                    for (int b = 0; b < 16; b++)
                        if (wr_be[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                end else if (rd_valid && rd_ready) begin
                    if (ram_ceb !== 1'b0 || ram_web !== 1'b1 || ram_a !== rd_addr) begin
                        n_fail++;
                        $display("FAIL ram_read_drive: ceb=%b web=%b a=%h, required 0 1 %h",
                                 ram_ceb, ram_web, ram_a, rd_addr);
                    end
                    q.push_back(ref_mem[rd_addr]);
                end else begin
                    if (ram_ceb !== 1'b1 || ram_web !== 1'b1 || ram_bweb !== 16'hFFFF) begin
                        n_fail++;
                        $display("FAIL ram_idle: ceb=%b web=%b bweb=%h, required 1 1 ffff",
                                 ram_ceb, ram_web, ram_bweb);
                    end
                end
                if (prev_stall) begin
                    n_checks++;
                    if (rsp_valid !== 1'b1 || rsp_data !== prev_data) begin
                        n_fail++;
                        $display("FAIL rsp_hold: valid=%b data=%h, required 1 %h",
                                 rsp_valid, rsp_data, prev_data);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_spurious: data=%h with no read outstanding", rsp_data);
                    end else begin
                        exp_d = q.pop_front();
                        if (rsp_data !== exp_d) begin
                            n_fail++;
                            $display("FAIL rsp_data: got %h, required %h", rsp_data, exp_d);
                        end
                    end
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev_data  = rsp_data;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [127:0] d,
                            input logic [15:0] be);
        bit ok;
        ok       = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) ok = 1'b1;
            next_cycle();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_timeout: addr=%h not accepted within 20 cycles", a);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = 8'h33;
        rd_addr  = 8'h44;
        wr_data  = {4{$urandom}};
        wr_be    = 16'h1234;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: wr=%b rd=%b, required 0 0", wr_ready, rd_ready);
        end
        n_checks++;
        if (ram_ceb !== 1'b1 || ram_web !== 1'b1 || ram_bweb !== 16'hFFFF ||
            ram_a !== 8'h00 || ram_d !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_ram: ceb=%b web=%b bweb=%h a=%h d=%h, required idle",
                     ram_ceb, ram_web, ram_bweb, ram_a, ram_d);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_write_read();
        logic [127:0] pat;
        pat       = {16{8'hA5}};
        rsp_ready = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 8'h10;
        wr_data   = pat;
        wr_be     = 16'hFFFF;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b1 || ram_web !== 1'b0 || ram_bweb !== 16'h0000) begin
            n_fail++;
            $display("FAIL full_write: wr_ready=%b web=%b bweb=%h, required 1 0 0000",
                     wr_ready, ram_web, ram_bweb);
        end
        next_cycle();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 8'h10;
        @(negedge clk);
        n_checks++;
        if (rd_ready !== 1'b1 || ram_ceb !== 1'b0 || ram_web !== 1'b1) begin
            n_fail++;
            $display("FAIL read_issue: rd_ready=%b ceb=%b web=%b, required 1 0 1",
                     rd_ready, ram_ceb, ram_web);
        end
        next_cycle();
        rd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_t1: rsp_valid=%b busy=%b, required 0 1", rsp_valid, busy);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== pat) begin
            n_fail++;
            $display("FAIL read_t2: rsp_valid=%b data=%h, required 1 %h",
                     rsp_valid, rsp_data, pat);
        end
        next_cycle();
    endtask

    task automatic test_partial_write();
        logic [127:0] expd;
        logic [127:0] got;
        bit           seen;
        expd     = {{15{8'hA5}}, 8'hFF};
        got      = '0;
        seen     = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 8'h10;
        wr_data  = 128'hFF;
        wr_be    = 16'h0001;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b1 || ram_bweb !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL partial_bweb: wr_ready=%b bweb=%h, required 1 fffe",
                     wr_ready, ram_bweb);
        end
        next_cycle();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 8'h10;
        next_cycle();
        rd_valid = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                got  = rsp_data;
            end
            next_cycle();
        end
        n_checks++;
        if (!seen || got !== expd) begin
            n_fail++;
            $display("FAIL partial_readback: seen=%b data=%h, required %h", seen, got, expd);
        end
        // An all-zero byte mask is an access that changes nothing.
        do_write(8'h10, 128'h0, 16'h0000);
        rd_valid = 1'b1;
        next_cycle();
        rd_valid = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_arbitration();
        bit exp_w;
        exp_w     = 1'b1;
        rsp_ready = 1'b1;
        wr_valid  = 1'b1;
        rd_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_addr = 8'($urandom_range(0, 7));
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_be   = 16'($urandom);
            rd_addr = 8'($urandom_range(0, 7));
            @(negedge clk);
            n_checks++;
            if (wr_ready !== exp_w || rd_ready !== !exp_w) begin
                n_fail++;
                $display("FAIL arb_alternate[%0d]: wr_ready=%b rd_ready=%b, required %b %b",
                         i, wr_ready, rd_ready, exp_w, !exp_w);
            end
            exp_w = !exp_w;
            next_cycle();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (4) next_cycle();
    endtask

    task automatic test_back_to_back();
        int idx;
        int pops;
        int cyc;
        int first;
        int last;
        for (int i = 0; i < 8; i++)
            do_write(8'(32 + i), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        idx       = 0;
        rd_addr   = 8'h20;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rd_ready === 1'b1) idx++;
            next_cycle();
            rd_addr = 8'(32 + idx);
        end
        @(negedge clk);
        n_checks++;
        if (idx !== 2 || rd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_stall: accepted=%0d rd_ready=%b rsp_valid=%b, required 2 0 1",
                     idx, rd_ready, rsp_valid);
        end
        next_cycle();
        rsp_ready = 1'b1;
        pops  = 0;
        first = -1;
        last  = -1;
        cyc   = 0;
        while (pops < 8 && cyc < 60) begin
            @(negedge clk);
            if (rd_valid && rd_ready === 1'b1) idx++;
            if (rsp_valid === 1'b1) begin
                pops++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            next_cycle();
            cyc++;
            if (idx >= 8) rd_valid = 1'b0;
            else rd_addr = 8'(32 + idx);
        end
        rd_valid = 1'b0;
        n_checks++;
        if (pops !== 8 || idx !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: responses=%0d accepts=%0d, required 8 8", pops, idx);
        end
        n_checks++;
        if (last - first !== 7) begin
            n_fail++;
            $display("FAIL b2b_rate: 8 responses spanned %0d cycles, required 8",
                     last - first + 1);
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_toggle_stall();
        int idx;
        int pops;
        int cyc;
        bit held;
        logic [127:0] hold_d;
        idx       = 0;
        pops      = 0;
        cyc       = 0;
        held      = 1'b0;
        hold_d    = '0;
        rd_valid  = 1'b1;
        rd_addr   = 8'h20;
        rsp_ready = 1'b1;
        while (pops < 8 && cyc < 80) begin
            @(negedge clk);
            if (held) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== hold_d) begin
                    n_fail++;
                    $display("FAIL toggle_hold: valid=%b data=%h, required 1 %h",
                             rsp_valid, rsp_data, hold_d);
                end
            end
            held   = (rsp_valid === 1'b1) && !rsp_ready;
            hold_d = rsp_data;
            if (rd_valid && rd_ready === 1'b1) idx++;
            if (rsp_valid === 1'b1 && rsp_ready) pops++;
            next_cycle();
            cyc++;
            rsp_ready = ~rsp_ready;
            if (idx >= 8) rd_valid = 1'b0;
            else rd_addr = 8'(32 + (idx % 8));
        end
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        n_checks++;
        if (pops !== 8 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_drain: responses=%0d busy=%b rsp_valid=%b, required 8 0 0",
                     pops, busy, rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_random();
        int rds;
        int pops;
        rds  = 0;
        pops = 0;
        for (int c = 0; c < 300; c++) begin
            wr_valid  = ($urandom_range(0, 99) < 40);
            rd_valid  = ($urandom_range(0, 99) < 60);
            rsp_ready = ($urandom_range(0, 99) < 70);
            wr_addr   = 8'($urandom_range(0, 7));
            rd_addr   = 8'($urandom_range(0, 7));
            wr_data   = {$urandom, $urandom, $urandom, $urandom};
            wr_be     = 16'($urandom);
            @(negedge clk);
            if (rd_valid && rd_ready === 1'b1) rds++;
            if (rsp_valid === 1'b1 && rsp_ready) pops++;
            next_cycle();
        end
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pops++;
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (pops !== rds || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: responses=%0d reads=%0d busy=%b, required equal, busy 0",
                     pops, rds, busy);
        end
        next_cycle();
    endtask

    task automatic test_mid_reset();
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 8'h21;
        repeat (5) next_cycle();
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_full: rsp_valid=%b rd_ready=%b busy=%b, required 1 0 1",
                     rsp_valid, rd_ready, busy);
        end
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || ram_ceb !== 1'b1 || ram_bweb !== 16'hFFFF ||
            rd_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: rsp_valid=%b ceb=%b bweb=%h rd_ready=%b busy=%b",
                     rsp_valid, ram_ceb, ram_bweb, rd_ready, busy);
        end
        repeat (2) next_cycle();
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_rsp[%0d]: rsp_valid=%b, required 0", c, rsp_valid);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b0;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        fork
            scoreboard();
        join_none
        test_reset();
        test_write_read();
        test_partial_write();
        test_arbitration();
        test_back_to_back();
        test_toggle_stall();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
